// File: rtl/trap_redirect_ctrl_pkg.sv
// trap_pkg: cause encodings and FSM states shared by the trap redirect controller
package trap_pkg;
  localparam logic [2:0] CAUSE_NONE     = 3'd0;
  localparam logic [2:0] CAUSE_MRET     = 3'd1;
  localparam logic [2:0] CAUSE_ECALL    = 3'd2;
  localparam logic [2:0] CAUSE_EBREAK   = 3'd3;
  localparam logic [2:0] CAUSE_MIS      = 3'd4;
  localparam logic [2:0] CAUSE_JALR_MIS = 3'd5;
  localparam logic [2:0] CAUSE_J_MIS    = 3'd6;
  typedef enum logic [1:0] {ST_IDLE, ST_REDIRECT, ST_FLUSH} state_t;
endpackage

// File: rtl/trap_cause_prio.sv
// trap_cause_prio: priority encoder from the six take pulses to {any_take, cause}
module trap_cause_prio
  import trap_pkg::*;
(
  input  logic       ecall_take,
  input  logic       ebreak_take,
  input  logic       mret_take,
  input  logic       misalign_take,
  input  logic       jalr_misalign_take,
  input  logic       j_misalign_take,
  output logic       any_take,
  output logic [2:0] cause
);
  assign any_take = ecall_take | ebreak_take | mret_take | misalign_take | jalr_misalign_take | j_misalign_take;
  assign cause = j_misalign_take    ? CAUSE_J_MIS    :
                 jalr_misalign_take ? CAUSE_JALR_MIS :
                 misalign_take      ? CAUSE_MIS      :
                 ebreak_take        ? CAUSE_EBREAK   :
                 ecall_take         ? CAUSE_ECALL    :
                 mret_take          ? CAUSE_MRET     : CAUSE_NONE;
endmodule

// File: rtl/trap_redirect_ctrl.sv
// trap_redirect_ctrl: turns trap/return take pulses into one fetch redirect plus a flush window (optional counter: TRAP_REDIRECT_CNT_EN)
module trap_redirect_ctrl
  import trap_pkg::*;
#(
  parameter int XLEN         = 32,
  parameter int FLUSH_CYCLES = 2,
  parameter int CNT_W        = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ecall_take,
  input  logic             ebreak_take,
  input  logic             mret_take,
  input  logic             misalign_take,
  input  logic             jalr_misalign_take,
  input  logic             j_misalign_take,
  input  logic [XLEN-1:0]  trap_addr,
  input  logic             fetch_ready,
  output logic             redirect_valid,
  output logic [XLEN-1:0]  redirect_pc,
  output logic             flush_if,
  output logic             flush_id,
  output logic             flush_ex,
  output logic             stall_pipe,
  output logic [2:0]       trap_cause,
  output logic             trap_busy,
  output logic [CNT_W-1:0] trap_count
);
  localparam int FC_W = FLUSH_CYCLES > 1 ? $clog2(FLUSH_CYCLES) : 1;
  localparam logic [FC_W-1:0] FC_LOAD = FC_W'(FLUSH_CYCLES > 0 ? FLUSH_CYCLES - 1 : 0);
  logic            any_take;
  logic [2:0]      cause;
  state_t          state;
  logic [FC_W-1:0] flush_cnt;
  logic            flush;
  trap_cause_prio u_prio (
    .ecall_take         (ecall_take),
    .ebreak_take        (ebreak_take),
    .mret_take          (mret_take),
    .misalign_take      (misalign_take),
    .jalr_misalign_take (jalr_misalign_take),
    .j_misalign_take    (j_misalign_take),
    .any_take           (any_take),
    .cause              (cause)
  );
  assign flush_if = flush;
  assign flush_id = flush;
  assign flush_ex = flush;
  // Redirect FSM: capture in IDLE, hold request until fetch accepts, then count down the flush window
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= ST_IDLE;
      flush_cnt      <= '0;
      redirect_valid <= 1'b0;
      redirect_pc    <= '0;
      flush          <= 1'b0;
      stall_pipe     <= 1'b0;
      trap_cause     <= CAUSE_NONE;
      trap_busy      <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: if (any_take) begin
          state          <= ST_REDIRECT;
          redirect_pc    <= trap_addr & ~XLEN'(3);
          trap_cause     <= cause;
          redirect_valid <= 1'b1;
          flush          <= 1'b1;
          stall_pipe     <= 1'b1;
          trap_busy      <= 1'b1;
        end
        ST_REDIRECT: if (fetch_ready) begin
          redirect_valid <= 1'b0;
          stall_pipe     <= 1'b0;
          if (FLUSH_CYCLES > 0) begin
            state     <= ST_FLUSH;
            flush_cnt <= FC_LOAD;
          end else begin
            state     <= ST_IDLE;
            flush     <= 1'b0;
            trap_busy <= 1'b0;
          end
        end
        ST_FLUSH: if (flush_cnt == '0) begin
          state     <= ST_IDLE;
          flush     <= 1'b0;
          trap_busy <= 1'b0;
        end else begin
          flush_cnt <= flush_cnt - 1'b1;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end
`ifdef TRAP_REDIRECT_CNT_EN
  // Count accepted redirect handshakes, wrapping naturally at the counter width
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) trap_count <= '0;
    else if (state == ST_REDIRECT && fetch_ready) trap_count <= trap_count + 1'b1;
  end
`else
  assign trap_count = '0;
`endif
endmodule

// File: tb/tb_trap_redirect_ctrl.sv
// tb_trap_redirect_ctrl: directed bench for trap_redirect_ctrl (FLUSH_CYCLES=2, CNT_W=4)
module tb_trap_redirect_ctrl;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        ecall_take = 1'b0, ebreak_take = 1'b0, mret_take = 1'b0;
  logic        misalign_take = 1'b0, jalr_misalign_take = 1'b0, j_misalign_take = 1'b0;
  logic [31:0] trap_addr = '0;
  logic        fetch_ready = 1'b0;
  logic        redirect_valid, flush_if, flush_id, flush_ex, stall_pipe, trap_busy;
  logic [31:0] redirect_pc;
  logic [2:0]  trap_cause;
  logic [3:0]  trap_count;
  int checks = 0;
  int failures = 0;
  int hs = 0;

  trap_redirect_ctrl #(.XLEN(32), .FLUSH_CYCLES(2), .CNT_W(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .ecall_take(ecall_take), .ebreak_take(ebreak_take), .mret_take(mret_take),
    .misalign_take(misalign_take), .jalr_misalign_take(jalr_misalign_take),
    .j_misalign_take(j_misalign_take), .trap_addr(trap_addr), .fetch_ready(fetch_ready),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .flush_if(flush_if), .flush_id(flush_id), .flush_ex(flush_ex),
    .stall_pipe(stall_pipe), .trap_cause(trap_cause), .trap_busy(trap_busy),
    .trap_count(trap_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_takes();
    {ecall_take, ebreak_take, mret_take, misalign_take, jalr_misalign_take, j_misalign_take} = '0;
  endtask

  function automatic logic [31:0] exp_cnt();
`ifdef TRAP_REDIRECT_CNT_EN
    return 32'(hs % 16);
`else
    return 32'd0;
`endif
  endfunction

  task automatic chk_state(input string tag, input logic v, input logic f, input logic s, input logic b);
    chk({tag, "_valid"}, {31'd0, redirect_valid}, {31'd0, v});
    chk({tag, "_flush"}, {29'd0, flush_if, flush_id, flush_ex}, {29'd0, f, f, f});
    chk({tag, "_stall"}, {31'd0, stall_pipe}, {31'd0, s});
    chk({tag, "_busy"},  {31'd0, trap_busy}, {31'd0, b});
  endtask

  initial begin
    #1;
    chk_state("rst", 0, 0, 0, 0);
    chk("rst_pc", redirect_pc, 32'h0);
    chk("rst_cause", {29'd0, trap_cause}, 32'd0);
    chk("rst_count", {28'd0, trap_count}, 32'd0);
    step(); step();
    rst_n = 1'b1;
    step();
    // 1: ecall, fetch ready immediately
    ecall_take = 1; trap_addr = 32'h104; fetch_ready = 1;
    step(); clear_takes();
    chk_state("t1_n1", 1, 1, 1, 1);
    chk("t1_pc", redirect_pc, 32'h104);
    chk("t1_cause", {29'd0, trap_cause}, 32'd2);
    step(); hs++;
    chk_state("t1_n2", 0, 1, 0, 1);
    step();
    chk_state("t1_n3", 0, 1, 0, 1);
    step();
    chk_state("t1_n4", 0, 0, 0, 0);
    chk("t1_cause_hold", {29'd0, trap_cause}, 32'd2);
    chk("t1_count", {28'd0, trap_count}, exp_cnt());
    // 2: mret, fetch stalls 3 cycles
    mret_take = 1; trap_addr = 32'h203; fetch_ready = 0;
    step(); clear_takes();
    chk_state("t2_c1", 1, 1, 1, 1);
    chk("t2_pc1", redirect_pc, 32'h200);
    chk("t2_cause", {29'd0, trap_cause}, 32'd1);
    step();
    chk_state("t2_c2", 1, 1, 1, 1);
    chk("t2_pc2", redirect_pc, 32'h200);
    step();
    chk_state("t2_c3", 1, 1, 1, 1);
    chk("t2_pc3", redirect_pc, 32'h200);
    fetch_ready = 1;
    step(); hs++;
    chk_state("t2_hs", 0, 1, 0, 1);
    step(); step();
    chk_state("t2_idle", 0, 0, 0, 0);
    // 3: simultaneous j_misalign + ecall
    j_misalign_take = 1; ecall_take = 1; trap_addr = 32'h1000;
    step(); clear_takes();
    chk_state("t3_n1", 1, 1, 1, 1);
    chk("t3_cause", {29'd0, trap_cause}, 32'd6);
    step(); hs++;
    step(); step();
    chk_state("t3_idle", 0, 0, 0, 0);
    step();
    chk_state("t3_one_redirect", 0, 0, 0, 0);
    // 4: ebreak during REDIRECT ignored; take on return-to-IDLE cycle ignored
    ecall_take = 1; trap_addr = 32'h400; fetch_ready = 0;
    step(); clear_takes();
    chk("t4_pc0", redirect_pc, 32'h400);
    ebreak_take = 1; trap_addr = 32'h300;
    step(); clear_takes();
    chk_state("t4_hold", 1, 1, 1, 1);
    chk("t4_pc1", redirect_pc, 32'h400);
    chk("t4_cause", {29'd0, trap_cause}, 32'd2);
    fetch_ready = 1;
    step(); hs++;
    ebreak_take = 1;
    step(); clear_takes();
    chk("t4_pc_flush", redirect_pc, 32'h400);
    mret_take = 1; trap_addr = 32'h500;
    step(); clear_takes();
    chk_state("t4_ret_idle_take", 0, 0, 0, 0);
    step();
    chk_state("t4_no_second", 0, 0, 0, 0);
    jalr_misalign_take = 1; trap_addr = 32'h506;
    step(); clear_takes();
    chk_state("t4_next_take", 1, 1, 1, 1);
    chk("t4_next_pc", redirect_pc, 32'h504);
    chk("t4_next_cause", {29'd0, trap_cause}, 32'd5);
    step(); hs++;
    step(); step();
    chk("t4_count", {28'd0, trap_count}, exp_cnt());
    // 5: async reset mid-FLUSH
    misalign_take = 1; trap_addr = 32'h700;
    step(); clear_takes();
    step(); hs++;
    chk_state("t5_in_flush", 0, 1, 0, 1);
    rst_n = 1'b0;
    #1;
    chk_state("t5_async", 0, 0, 0, 0);
    chk("t5_pc", redirect_pc, 32'h0);
    chk("t5_cause", {29'd0, trap_cause}, 32'd0);
    chk("t5_count", {28'd0, trap_count}, 32'd0);
    hs = 0;
    #3 rst_n = 1'b1;
    misalign_take = 1; trap_addr = 32'h604;
    step(); clear_takes();
    chk_state("t5_after", 1, 1, 1, 1);
    chk("t5_after_pc", redirect_pc, 32'h604);
    chk("t5_after_cause", {29'd0, trap_cause}, 32'd4);
    step(); hs++;
    step(); step();
    // 6: 16 more redirects, 17 total since reset -> wraps to 1 with the counter enabled
    for (int i = 0; i < 16; i++) begin
      ecall_take = 1; trap_addr = 32'h800 + 32'(i * 4);
      step(); clear_takes();
      step(); hs++;
      step(); step();
    end
    chk_state("t6_idle", 0, 0, 0, 0);
    chk("t6_count", {28'd0, trap_count}, exp_cnt());
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule
